// File: rtl/cda_delay_averager.sv
// cda_delay_averager
//   Averages 2**LOG2_N delay indices from the CDA encoder per window and
//   reports the window mean (rounded half up) plus the spread (max - min).
//   The result is offered on a valid/ready interface toward the direction
//   estimator. Out-of-range indices are counted and discarded. In-range
//   samples that arrive while a result is pending are dropped and latch
//   the sticky overrun flag.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   en            global enable; when low, all state holds
//   delay_in      delay index from the encoder
//   delay_valid   delay_in strobe
//   avg_delay     registered rounded window mean
//   avg_spread    registered max - min of the window
//   avg_valid     result pending, held until accepted
//   avg_ready     consumer accepts the result
//   overrun       sticky, in-range sample dropped while not accumulating
//   reject_cnt    saturating count of indices above MAX_IDX
module cda_delay_averager #(
   parameter int IDX_W   = 7,
   parameter int MAX_IDX = 86,
   parameter int LOG2_N  = 4,
   parameter int REJ_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [IDX_W-1:0] delay_in,
   input  logic             delay_valid,
   output logic [IDX_W-1:0] avg_delay,
   output logic [IDX_W-1:0] avg_spread,
   output logic             avg_valid,
   input  logic             avg_ready,
   output logic             overrun,
   output logic [REJ_W-1:0] reject_cnt
);

   localparam int ACC_W = IDX_W + LOG2_N;
   localparam logic [IDX_W-1:0] MAX_V = IDX_W'(MAX_IDX);
   // One extra bit so the rounding bias cannot wrap the sum.
   localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (LOG2_N - 1);

   typedef enum logic [1:0] {ACCUM, CALC, HOLD} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [LOG2_N-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]   min_q, min_d;
   logic [IDX_W-1:0]   max_q, max_d;
   logic [IDX_W-1:0]   avg_delay_q, avg_delay_d;
   logic [IDX_W-1:0]   avg_spread_q, avg_spread_d;
   logic               overrun_q, overrun_d;
   logic [REJ_W-1:0]   rej_q, rej_d;

   logic               out_of_range;
   logic               accept;
   logic               reject;
   logic               drop;
   logic               handshake;
   logic [ACC_W:0]     rounded;

   always_comb begin
      out_of_range = delay_in > MAX_V;
      accept       = en && delay_valid && !out_of_range && (state_q == ACCUM);
      reject       = en && delay_valid && out_of_range;
      drop         = en && delay_valid && !out_of_range && (state_q != ACCUM);
      handshake    = en && avg_ready && (state_q == HOLD);
      rounded      = {1'b0, acc_q} + HALF;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            ACCUM:   if (accept && (cnt_q == '1)) state_d = CALC;
            CALC:    state_d = HOLD;
            HOLD:    if (avg_ready) state_d = ACCUM;
            default: state_d = ACCUM;
         endcase
      end
   end

   // Output logic: valid is decoded from the state register only
   always_comb begin
      avg_valid = (state_q == HOLD);
   end

   // Datapath next values
   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      min_d        = min_q;
      max_d        = max_q;
      avg_delay_d  = avg_delay_q;
      avg_spread_d = avg_spread_q;
      overrun_d    = overrun_q;
      rej_d        = rej_q;

      if (accept) begin
         acc_d = acc_q + ACC_W'(delay_in);
         cnt_d = cnt_q + LOG2_N'(1);
         if (delay_in < min_q) min_d = delay_in;
         if (delay_in > max_q) max_d = delay_in;
      end

      if (en && (state_q == CALC)) begin
         avg_delay_d  = IDX_W'(rounded >> LOG2_N);
         avg_spread_d = max_q - min_q;
      end

      if (handshake) begin
         acc_d = '0;
         cnt_d = '0;
         min_d = '1;
         max_d = '0;
      end

      if (reject && (rej_q != '1)) rej_d = rej_q + REJ_W'(1);
      if (drop) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         min_q        <= '1;
         max_q        <= '0;
         avg_delay_q  <= '0;
         avg_spread_q <= '0;
         overrun_q    <= 1'b0;
         rej_q        <= '0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         min_q        <= min_d;
         max_q        <= max_d;
         avg_delay_q  <= avg_delay_d;
         avg_spread_q <= avg_spread_d;
         overrun_q    <= overrun_d;
         rej_q        <= rej_d;
      end
   end

   assign avg_delay  = avg_delay_q;
   assign avg_spread = avg_spread_q;
   assign overrun    = overrun_q;
   assign reject_cnt = rej_q;

endmodule

// File: tb/tb_cda_delay_averager.sv
module tb_cda_delay_averager;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [6:0] delay_in;
   logic       delay_valid;
   logic [6:0] avg_delay;
   logic [6:0] avg_spread;
   logic       avg_valid;
   logic       avg_ready;
   logic       overrun;
   logic [7:0] reject_cnt;

   int total = 0;
   int bad   = 0;

   cda_delay_averager #(
      .IDX_W  (7),
      .MAX_IDX(86),
      .LOG2_N (4),
      .REJ_W  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .delay_in   (delay_in),
      .delay_valid(delay_valid),
      .avg_delay  (avg_delay),
      .avg_spread (avg_spread),
      .avg_valid  (avg_valid),
      .avg_ready  (avg_ready),
      .overrun    (overrun),
      .reject_cnt (reject_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      delay_in    = 7'(v);
      delay_valid = 1'b1;
      tick();
      delay_valid = 1'b0;
   endtask

   task automatic send_n(input int v, input int n);
      for (int i = 0; i < n; i++) send(v);
   endtask

   initial begin
      rst         = 1'b1;
      en          = 1'b1;
      delay_in    = '0;
      delay_valid = 1'b0;
      avg_ready   = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check("rst_avg_delay", avg_delay, 0);
      check("rst_avg_spread", avg_spread, 0);
      check("rst_avg_valid", avg_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_reject_cnt", reject_cnt, 0);

      // Basic average: 16 x 40
      send_n(40, 16);
      check("basic_valid_in_calc", avg_valid, 0);
      tick();
      check("basic_valid", avg_valid, 1);
      check("basic_avg", avg_delay, 40);
      check("basic_spread", avg_spread, 0);
      tick();
      check("basic_valid_one_cycle", avg_valid, 0);
      check("basic_avg_retained", avg_delay, 40);

      // Rounding: 8 x 10 + 8 x 11 = 168 -> 10.5 -> 11
      send_n(10, 8);
      send_n(11, 8);
      tick();
      check("round_avg", avg_delay, 11);
      check("round_spread", avg_spread, 1);
      tick();

      // Half rounds up: 15 x 0 + 8 = 8 -> 0.5 -> 1
      send_n(0, 15);
      send(8);
      tick();
      check("half_avg", avg_delay, 1);
      check("half_spread", avg_spread, 8);
      tick();

      // Rejects interleaved with a 16 x 20 window
      for (int i = 0; i < 16; i++) begin
         send(20);
         if (i == 2 || i == 6 || i == 10) send(100);
         if (i == 13) send(127);
      end
      tick();
      check("rej_valid", avg_valid, 1);
      check("rej_avg", avg_delay, 20);
      check("rej_spread", avg_spread, 0);
      check("rej_cnt4", reject_cnt, 4);
      check("rej_overrun", overrun, 0);
      tick();
      send_n(127, 300);
      check("rej_saturate", reject_cnt, 255);
      check("rej_no_window", avg_valid, 0);

      // Backpressure: hold result, drop two samples during HOLD
      avg_ready = 1'b0;
      send_n(60, 16);
      tick();
      check("bp_valid", avg_valid, 1);
      check("bp_avg", avg_delay, 60);
      check("bp_overrun_before", overrun, 0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3)      send(5);
         else if (i == 7) send(80);
         else             tick();
      end
      check("bp_overrun", overrun, 1);
      check("bp_avg_held", avg_delay, 60);
      check("bp_valid_held", avg_valid, 1);
      avg_ready = 1'b1;
      tick();
      check("bp_handshake", avg_valid, 0);
      send_n(70, 16);
      tick();
      check("bp_next_avg", avg_delay, 70);
      check("bp_next_spread", avg_spread, 0);
      tick();

      // Enable gating
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("en_rst_overrun", overrun, 0);
      check("en_rst_rej", reject_cnt, 0);
      send_n(30, 6);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         delay_valid = 1'b1;
         delay_in    = (i % 2 == 1) ? 7'd120 : 7'd50;
         tick();
      end
      delay_valid = 1'b0;
      en = 1'b1;
      send_n(30, 9);
      tick();
      tick();
      check("en_not_done_at_15", avg_valid, 0);
      send(30);
      tick();
      check("en_valid", avg_valid, 1);
      check("en_avg", avg_delay, 30);
      check("en_spread", avg_spread, 0);
      check("en_rej_gated", reject_cnt, 0);
      tick();

      // Reset mid-window and while a result is pending
      send_n(10, 9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_avg", avg_delay, 0);
      check("mid_rst_valid", avg_valid, 0);
      avg_ready = 1'b0;
      send_n(5, 16);
      tick();
      check("mid_win_valid", avg_valid, 1);
      check("mid_win_avg", avg_delay, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("hold_rst_valid", avg_valid, 0);
      check("hold_rst_avg", avg_delay, 0);
      check("hold_rst_spread", avg_spread, 0);
      avg_ready = 1'b1;
      send_n(33, 16);
      tick();
      check("post_rst_valid", avg_valid, 1);
      check("post_rst_avg", avg_delay, 33);
      check("post_rst_spread", avg_spread, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cda_delay_averager.md
# cda_delay_averager

Post-processing stage that sits directly downstream of the CDA correlator/encoder. It accepts the binary delay index produced for each correlation result and averages 2^LOG2_N indices per window. It also reports the spread (max − min) of each window and presents the result on a valid/ready output toward the direction-estimation logic. Out-of-range indices are rejected, and samples lost to output backpressure are flagged.

## Interface
- IDX_W, 7: width of the delay index from the encoder.
- MAX_IDX, 86: largest legal index (STAGES − 1); larger values are rejected.
- LOG2_N, 4: log2 of samples per window (N = 16); legal range 1..8.
- REJ_W, 8: width of the saturating reject counter.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, all registers hold and no handshake completes.
- delay_in  input  IDX_W  delay index from the encoder.
- delay_valid  input  1  delay_in is valid this cycle (single-cycle strobe per result).
- avg_delay  output  IDX_W  rounded window mean.
- avg_spread  output  IDX_W  max − min of accepted samples in the window.
- avg_valid  output  1  result available; held until accepted.
- avg_ready  input  1  consumer accepts the result when high together with avg_valid and en.
- overrun  output  1  sticky; set when a valid, in-range sample is dropped while not accumulating.
- reject_cnt  output  REJ_W  saturating count of samples with delay_in > MAX_IDX.

## Operation
- Accumulator width: IDX_W + LOG2_N bits; it never overflows.
- Sample counter width: LOG2_N bits.
- Running min and max registers, IDX_W bits each.
- FSM states:
  - ACCUM (reset state): on accept, add delay_in to acc, update min/max, increment count. When the accepted sample is the N-th (count == N−1), go to CALC.
  - CALC (exactly one cycle):
    - avg_delay ← (acc + 2^(LOG2_N−1)) >> LOG2_N, i.e. round half up; the result is always ≤ MAX_IDX.
    - avg_spread ← max − min.
    - Go to HOLD.
  - HOLD:
    - avg_valid = 1.
    - On avg_valid && avg_ready && en: clear acc and count, set min ← all-ones and max ← 0, return to ACCUM.
- Accept condition: en && delay_valid && state == ACCUM && delay_in ≤ MAX_IDX.
- Reject: en && delay_valid && delay_in > MAX_IDX, in any state.
  - reject_cnt increments and saturates at 2^REJ_W − 1.
  - The sample never enters the accumulator or min/max.
  - Rejection takes precedence over overrun.
- Overrun: en && delay_valid && in-range while in CALC or HOLD.
  - The sample is dropped and overrun ← 1.
  - This includes the handshake cycle itself; the first sample of the new window must arrive at least one cycle after the handshake.
- First-sample min/max: the reset/cleared values (all-ones, 0) guarantee that the first accepted sample sets both min and max.
- en low: FSM, counters, flags and outputs hold; delay_valid and avg_ready are ignored.
- rst: synchronous, overrides en and aborts any partial window. Reset values: state ACCUM, acc 0, count 0, min all-ones, max 0, avg_delay 0, avg_spread 0, avg_valid 0, overrun 0, reject_cnt 0.
- overrun clears only on rst.

## Timing
- Latency: N-th sample accepted at edge t (en high throughout) → CALC during cycle t+1 → avg_valid = 1 from edge t+2.
- avg_delay and avg_spread are registered; they are valid whenever avg_valid = 1 and stable until the next CALC.
- Handshake at edge h: avg_valid = 0 from h+1, and the block accepts samples from cycle h+1.
- avg_ready high during CALC has no effect.
- avg_delay and avg_spread retain their last values after the handshake; they update only in CALC.
- Throughput: at most one sample per cycle. Minimum window period is N + 2 cycles when avg_ready is held high.
- No combinational path from any input to any output.

## Test plan
- Basic average: reset, avg_ready = 1, 16 samples of 40 on consecutive cycles → avg_delay = 40, avg_spread = 0, avg_valid rises 2 cycles after the 16th sample and stays high for exactly 1 cycle.
- Rounding and spread: 8 × 10 then 8 × 11 → sum 168, avg_delay = 11, avg_spread = 1. Repeat with 15 × 0 and 1 × 8 → sum 8, avg_delay = 1 (half rounds up), avg_spread = 8.
- Reject: 16 samples of 20 interleaved with 3 samples of 100 and 1 of 127 → avg_delay = 20, reject_cnt = 4, overrun = 0. Then 300 rejected samples → reject_cnt = 255 (saturated).
- Backpressure: avg_ready = 0 for 10 cycles after avg_valid; send 2 in-range samples during HOLD → overrun = 1, avg_delay unchanged. Raise avg_ready, then send 16 × 70 → avg_delay = 70, avg_spread = 0 (dropped samples excluded).
- en gating: during accumulation drop en for 5 cycles while pulsing delay_valid with 50 → accumulator and count unchanged. Resume; the window completes after exactly 16 en-qualified accepts.
- Reset mid-operation: assert rst after 9 accepted samples and again while avg_valid = 1 → all outputs return to reset values on the next edge, and the following 16 samples of 33 give avg_delay = 33.
